// File: rtl/spi_master.sv
// SPI mode-0 byte engine: shifts one byte out MSB first while capturing one byte in,
// plus a dummy-clock mode for waking or resetting attached memories.
module spi_master #(
  parameter int DIV_HALF   = 2,
  parameter int FORCE_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_tx,
  input  logic       txn_start,
  output logic [7:0] data_rx,
  output logic       txn_done,
  input  logic       force_clock,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int PW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int FW = $clog2(FORCE_BITS + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV_HALF - 1);
  localparam logic [FW-1:0] FRC_LAST = FW'(FORCE_BITS - 1);

  typedef enum logic [1:0] {IDLE, XFER, FORCE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [FW-1:0] frc_cnt, frc_cnt_nxt;
  logic          lead, lead_nxt;
  logic          sck_nxt, mosi_nxt, done_nxt;
  logic [7:0]    data_rx_nxt;
  logic [7:0]    tx_sh, tx_sh_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt;
  logic          phase_end;

  assign phase_end = (phase == PH_LAST);

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_cnt_nxt = bit_cnt;
    frc_cnt_nxt = frc_cnt;
    lead_nxt    = lead;
    sck_nxt     = spi_sck;
    mosi_nxt    = spi_mosi;
    done_nxt    = txn_done;
    data_rx_nxt = data_rx;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;

    case (state)
      IDLE: begin
        if (txn_start) begin
          state_nxt   = XFER;
          tx_sh_nxt   = data_tx;
          mosi_nxt    = data_tx[7];
          done_nxt    = 1'b0;
          phase_nxt   = '0;
          bit_cnt_nxt = '0;
          lead_nxt    = 1'b1;
          sck_nxt     = 1'b0;
        end else if (force_clock) begin
          state_nxt   = FORCE;
          mosi_nxt    = 1'b1;
          done_nxt    = 1'b0;
          phase_nxt   = '0;
          frc_cnt_nxt = '0;
          lead_nxt    = 1'b1;
          sck_nxt     = 1'b0;
        end
      end

      XFER, FORCE: begin
        // One extra lead-in cycle before phase counting gives the first low phase MOSI setup time.
        if (lead) begin
          lead_nxt = 1'b0;
        end else if (!phase_end) begin
          phase_nxt = phase + PW'(1);
        end else begin
          phase_nxt = '0;
          if (!spi_sck) begin
            sck_nxt = 1'b1;
            if (state == XFER) rx_sh_nxt = {rx_sh[6:0], spi_miso};
          end else begin
            sck_nxt = 1'b0;
            if (state == XFER) begin
              if (bit_cnt == 3'd7) begin
                data_rx_nxt = rx_sh;
                done_nxt    = 1'b1;
                state_nxt   = IDLE;
              end else begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                mosi_nxt    = tx_sh[6];
              end
            end else begin
              if (frc_cnt == FRC_LAST) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
              end else begin
                frc_cnt_nxt = frc_cnt + FW'(1);
              end
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      frc_cnt  <= '0;
      lead     <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      txn_done <= 1'b1;
      data_rx  <= 8'h00;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_cnt  <= bit_cnt_nxt;
      frc_cnt  <= frc_cnt_nxt;
      lead     <= lead_nxt;
      spi_sck  <= sck_nxt;
      spi_mosi <= mosi_nxt;
      txn_done <= done_nxt;
      data_rx  <= data_rx_nxt;
    end
  end

  // Shift registers carry no reset: they are always reloaded or fully refilled before use.
  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_nxt;
    rx_sh <= rx_sh_nxt;
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: DIV_HALF=2 instance for the main cases and a DIV_HALF=1 instance.
module tb_spi_master;

  localparam int LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       txn_start = 1'b0;
  logic       force_clock = 1'b0;
  logic [7:0] data_rx;
  logic       txn_done;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  logic [7:0] d1_tx = 8'h00;
  logic       d1_start = 1'b0;
  logic [7:0] d1_rx;
  logic       d1_done;
  logic       d1_sck;
  logic       d1_mosi;

  logic       slave_mode = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic       slv_bit;
  logic       mon_clr = 1'b0;
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic       mosi_low_seen = 1'b0;
  logic       sck_q = 1'b0;

  int checks = 0;
  int failures = 0;
  int low;

  always #5 clk = ~clk;

  spi_master #(.DIV_HALF(2), .FORCE_BITS(16)) dut (
    .clk(clk), .rst(rst), .data_tx(data_tx), .txn_start(txn_start),
    .data_rx(data_rx), .txn_done(txn_done), .force_clock(force_clock),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master #(.DIV_HALF(1), .FORCE_BITS(16)) dut1 (
    .clk(clk), .rst(rst), .data_tx(d1_tx), .txn_start(d1_start),
    .data_rx(d1_rx), .txn_done(d1_done), .force_clock(1'b0),
    .spi_sck(d1_sck), .spi_mosi(d1_mosi), .spi_miso(d1_mosi)
  );

  // Mode-0 slave: presents its MSB first and advances on each SCK falling edge.
  always_comb begin
    slv_bit = 1'b0;
    if (fall_cnt < 8) slv_bit = slv_byte[3'(7 - fall_cnt)];
  end
  assign spi_miso = slave_mode ? slv_bit : spi_mosi;

  always begin
    @(posedge clk);
    #1;
    if (mon_clr) begin
      rise_cnt = 0;
      fall_cnt = 0;
      mosi_cap = 8'h00;
      mosi_low_seen = 1'b0;
    end else begin
      if (spi_sck && !sck_q) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
      end
      if (!spi_sck && sck_q) fall_cnt++;
      if (!txn_done && !spi_mosi) mosi_low_seen = 1'b1;
    end
    sck_q = spi_sck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue a request, then count the cycles txn_done stays low; at low==mid fire a stray start+force.
  task automatic run0(input logic st, input logic fc, input logic [7:0] d, input int mid,
                      output int low_cnt);
    @(negedge clk);
    mon_clr = 1'b1;
    data_tx = d;
    txn_start = st;
    force_clock = fc;
    @(negedge clk);
    mon_clr = 1'b0;
    txn_start = 1'b0;
    force_clock = 1'b0;
    data_tx = ~d;
    low_cnt = 0;
    while (!txn_done && low_cnt < LIMIT) begin
      low_cnt++;
      txn_start = (low_cnt == mid);
      force_clock = (low_cnt == mid);
      @(negedge clk);
    end
    txn_start = 1'b0;
    force_clock = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_done", 32'(txn_done), 32'd1);
    check("rst_rx", 32'(data_rx), 32'h00);
    check("rst_d1_done", 32'(d1_done), 32'd1);
    check("rst_d1_sck", 32'(d1_sck), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: loopback A5
    run0(1'b1, 1'b0, 8'hA5, -1, low);
    check("t1_low", 32'(low), 32'd33);
    check("t1_rx", 32'(data_rx), 32'hA5);
    check("t1_mosi_bits", 32'(mosi_cap), 32'hA5);
    check("t1_rises", 32'(rise_cnt), 32'd8);
    check("t1_sck_end", 32'(spi_sck), 32'd0);
    check("t1_mosi_hold", 32'(spi_mosi), 32'd1);

    // 2: slave returns 3C while sending FF
    slave_mode = 1'b1;
    slv_byte = 8'h3C;
    run0(1'b1, 1'b0, 8'hFF, -1, low);
    check("t2_low", 32'(low), 32'd33);
    check("t2_rx", 32'(data_rx), 32'h3C);
    check("t2_rises", 32'(rise_cnt), 32'd8);
    check("t2_sck_end", 32'(spi_sck), 32'd0);
    check("t2_mosi_bits", 32'(mosi_cap), 32'hFF);
    slave_mode = 1'b0;

    // 3: force clocks
    run0(1'b0, 1'b1, 8'h00, -1, low);
    check("t3_low", 32'(low), 32'd65);
    check("t3_rises", 32'(rise_cnt), 32'd16);
    check("t3_mosi_low_seen", 32'(mosi_low_seen), 32'd0);
    check("t3_rx_kept", 32'(data_rx), 32'h3C);
    check("t3_sck_end", 32'(spi_sck), 32'd0);

    // 4: start+force together, stray requests mid-transfer
    run0(1'b1, 1'b1, 8'h5A, 12, low);
    check("t4_low", 32'(low), 32'd33);
    check("t4_rises", 32'(rise_cnt), 32'd8);
    check("t4_rx", 32'(data_rx), 32'h5A);
    @(negedge clk);
    check("t4_stays_idle", 32'(txn_done), 32'd1);

    // 5: asynchronous reset during the 4th bit
    @(negedge clk);
    data_tx = 8'hFF;
    txn_start = 1'b1;
    @(negedge clk);
    txn_start = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_pre_sck", 32'(spi_sck), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_sck", 32'(spi_sck), 32'd0);
    check("t5_mosi", 32'(spi_mosi), 32'd0);
    check("t5_done", 32'(txn_done), 32'd1);
    check("t5_rx", 32'(data_rx), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    run0(1'b1, 1'b0, 8'h96, -1, low);
    check("t5_after_low", 32'(low), 32'd33);
    check("t5_after_rx", 32'(data_rx), 32'h96);

    // 6: DIV_HALF=1 instance, including back-to-back start handling
    @(negedge clk);
    d1_tx = 8'h81;
    d1_start = 1'b1;
    @(negedge clk);
    d1_start = 1'b0;
    low = 0;
    while (!d1_done && low < LIMIT) begin
      low++;
      d1_start = (low == 17);
      if (low == 17) d1_tx = 8'h7E;
      @(negedge clk);
    end
    check("t6_low", 32'(low), 32'd17);
    check("t6_rx", 32'(d1_rx), 32'h81);
    check("t6_b2b_ignored", 32'(d1_done), 32'd1);
    d1_start = 1'b1;
    @(negedge clk);
    d1_start = 1'b0;
    check("t6_next_accepted", 32'(d1_done), 32'd0);
    low = 1;
    while (!d1_done && low < LIMIT) begin
      @(negedge clk);
      if (!d1_done) low++;
    end
    check("t6_next_low", 32'(low), 32'd17);
    check("t6_next_rx", 32'(d1_rx), 32'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
